// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizes, the
// hard-wired zero register index and the write-forwarding winner selection.
package regfile_pkg;

  localparam int unsigned DefaultXlen  = 32;
  localparam int unsigned DefaultNregs = 32;
  localparam int unsigned REG_ZERO     = 0;

  // Upper bound on write ports accepted by the forwarding selector.
  localparam int unsigned MaxWr = 16;

  // Index of the highest-numbered write port hitting the read address, -1 if none.
  function automatic int fwd_winner(input logic [MaxWr-1:0] hit);
    int win;
    win = -1;
    for (int j = 0; j < int'(MaxWr); j++) begin
      if (hit[j]) win = j;
    end
    return win;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Write scoreboard: per-register pending bits set at issue, cleared by writeback,
// plus the WAW issue handshake and per-read-port RAW lookup.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS     = DefaultNregs,
  parameter int unsigned NUM_RD    = 2,
  parameter bit          ZERO_REG0 = 1'b1,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic                 clk_pi,
  input  logic                 reset_pi,
  input  logic [NREGS-1:0]     clr_pi,
  input  logic                 iss_valid_pi,
  input  logic [AW-1:0]        iss_addr_pi,
  input  logic [NUM_RD*AW-1:0] rd_addr_pi,
  output logic                 iss_ready_po,
  output logic [NUM_RD-1:0]    rd_busy_po,
  output logic [NREGS-1:0]     busy_vec_po
);

  logic [NREGS-1:0] busy_q, busy_d, set;
  logic             iss_zero;

  assign iss_zero     = ZERO_REG0 && (iss_addr_pi == AW'(REG_ZERO));
  assign iss_ready_po = reset_pi | iss_zero | ~busy_q[iss_addr_pi] | clr_pi[iss_addr_pi];
  assign busy_vec_po  = busy_q;

  // A new producer in flight outranks a writeback from the previous one.
  always_comb begin
    set = '0;
    if (iss_valid_pi && iss_ready_po && !iss_zero) set[iss_addr_pi] = 1'b1;
    busy_d = set | (busy_q & ~clr_pi);
  end

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_busy_po = '0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      rd_busy_po[k] = busy_q[rd_addr_pi[k*AW +: AW]] & ~clr_pi[rd_addr_pi[k*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with same-cycle write forwarding and write scoreboard.
// Define REGFILE_RD_REG_EN to register read data/busy outputs (1-cycle read latency).
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN      = DefaultXlen,
  parameter int unsigned NREGS     = DefaultNregs,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned NUM_WR    = 2,
  parameter bit          ZERO_REG0 = 1'b1,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic                   clk_pi,
  input  logic                   reset_pi,
  input  logic [NUM_RD*AW-1:0]   rd_addr_pi,
  output logic [NUM_RD*XLEN-1:0] rd_data_po,
  output logic [NUM_RD-1:0]      rd_busy_po,
  input  logic [NUM_WR-1:0]      wr_en_pi,
  input  logic [NUM_WR*AW-1:0]   wr_addr_pi,
  input  logic [NUM_WR*XLEN-1:0] wr_data_pi,
  input  logic                   iss_valid_pi,
  input  logic [AW-1:0]          iss_addr_pi,
  output logic                   iss_ready_po,
  output logic [NREGS-1:0]       busy_vec_po
);

  logic [XLEN-1:0]        regs_q [NREGS];
  logic [NUM_WR-1:0]      wr_eff;
  logic [NREGS-1:0]       clr;
  logic [NUM_RD*XLEN-1:0] rd_data_c;
  logic [NUM_RD-1:0]      rd_busy_c;

  always_comb begin
    wr_eff = '0;
    clr    = '0;
    for (int j = 0; j < int'(NUM_WR); j++) begin
      wr_eff[j] = wr_en_pi[j] &&
                  !(ZERO_REG0 && (wr_addr_pi[j*AW +: AW] == AW'(REG_ZERO)));
      if (wr_eff[j]) clr[wr_addr_pi[j*AW +: AW]] = 1'b1;
    end
  end

  // Later ports are applied last, so the highest index wins an address conflict.
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      for (int r = 0; r < int'(NREGS); r++) regs_q[r] <= '0;
    end else begin
      for (int j = 0; j < int'(NUM_WR); j++) begin
        if (wr_eff[j]) regs_q[wr_addr_pi[j*AW +: AW]] <= wr_data_pi[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      logic [AW-1:0]    addr;
      logic [MaxWr-1:0] hit;
      int               win;
      addr = rd_addr_pi[k*AW +: AW];
      hit  = '0;
      for (int j = 0; j < int'(NUM_WR); j++) begin
        hit[j] = wr_eff[j] && (wr_addr_pi[j*AW +: AW] == addr);
      end
      win = fwd_winner(hit);
      if (ZERO_REG0 && (addr == AW'(REG_ZERO))) begin
        rd_data_c[k*XLEN +: XLEN] = '0;
      end else if (win >= 0) begin
        rd_data_c[k*XLEN +: XLEN] = wr_data_pi[win*XLEN +: XLEN];
      end else begin
        rd_data_c[k*XLEN +: XLEN] = regs_q[addr];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NUM_RD   (NUM_RD),
    .ZERO_REG0(ZERO_REG0)
  ) u_scoreboard (
    .clk_pi      (clk_pi),
    .reset_pi    (reset_pi),
    .clr_pi      (clr),
    .iss_valid_pi(iss_valid_pi),
    .iss_addr_pi (iss_addr_pi),
    .rd_addr_pi  (rd_addr_pi),
    .iss_ready_po(iss_ready_po),
    .rd_busy_po  (rd_busy_c),
    .busy_vec_po (busy_vec_po)
  );

`ifdef REGFILE_RD_REG_EN
  logic [NUM_RD*XLEN-1:0] rd_data_q;
  logic [NUM_RD-1:0]      rd_busy_q;

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      rd_data_q <= rd_data_c;
      rd_busy_q <= rd_busy_c;
    end
  end

  assign rd_data_po = rd_data_q;
  assign rd_busy_po = rd_busy_q;
`else
  assign rd_data_po = rd_data_c;
  assign rd_busy_po = rd_busy_c;
`endif

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Table-driven bench for regfile_mp_sb; read results go through an expectation
// queue so the same table works with or without registered read outputs.
module tb_regfile_mp_sb;

  localparam int NREGS = 32;
`ifdef REGFILE_RD_REG_EN
  localparam int Lat = 1;
`else
  localparam int Lat = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        iss_ready;
  logic [31:0] busy_vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp_sb #(
    .XLEN     (32),
    .NREGS    (NREGS),
    .NUM_RD   (2),
    .NUM_WR   (2),
    .ZERO_REG0(1'b1)
  ) dut (
    .clk_pi      (clk),
    .reset_pi    (reset),
    .rd_addr_pi  (rd_addr),
    .rd_data_po  (rd_data),
    .rd_busy_po  (rd_busy),
    .wr_en_pi    (wr_en),
    .wr_addr_pi  (wr_addr),
    .wr_data_pi  (wr_data),
    .iss_valid_pi(iss_valid),
    .iss_addr_pi (iss_addr),
    .iss_ready_po(iss_ready),
    .busy_vec_po (busy_vec)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        iv;
    logic [4:0]  ia;
    logic [4:0]  ra0, ra1;
    logic [31:0] ed0, ed1;
    logic [1:0]  eb;
    logic        er;
    logic [31:0] ebv;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] d0, d1;
    logic [1:0]  b;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  function automatic vec_t mk(input logic rst, input logic [1:0] we,
                              input logic [4:0] wa0, input logic [31:0] wd0,
                              input logic [4:0] wa1, input logic [31:0] wd1,
                              input logic iv, input logic [4:0] ia,
                              input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic [31:0] ed0, input logic [31:0] ed1,
                              input logic [1:0] eb, input logic er, input logic [31:0] ebv);
    vec_t v;
    v.rst = rst; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.iv = iv; v.ia = ia; v.ra0 = ra0; v.ra1 = ra1;
    v.ed0 = ed0; v.ed1 = ed1; v.eb = eb; v.er = er; v.ebv = ebv;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", nm, idx, act, exp);
    end
  endtask

  task automatic pop_cmp(input int keep);
    exp_t e;
    while (exp_q.size() > keep) begin
      e = exp_q.pop_front();
      chk("rd_data0", e.idx, rd_data[31:0], e.d0);
      chk("rd_data1", e.idx, rd_data[63:32], e.d1);
      chk("rd_busy", e.idx, {30'b0, rd_busy}, {30'b0, e.b});
    end
  endtask

  task automatic drive(input vec_t v);
    reset     = v.rst;
    wr_en     = v.we;
    wr_addr   = {v.wa1, v.wa0};
    wr_data   = {v.wd1, v.wd0};
    iss_valid = v.iv;
    iss_addr  = v.ia;
    rd_addr   = {v.ra1, v.ra0};
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(posedge clk);
    #1;
    drive(v);
    e.idx = idx; e.d0 = v.ed0; e.d1 = v.ed1; e.b = v.eb;
    exp_q.push_back(e);
    @(negedge clk);
    chk("iss_ready", idx, {31'b0, iss_ready}, {31'b0, v.er});
    chk("busy_vec", idx, busy_vec, v.ebv);
    pop_cmp(Lat);
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);

    drive(idle);
    reset    = 1'b1;
    iss_addr = 5'd5;
    @(posedge clk);
    @(negedge clk);
    chk("iss_ready_in_reset", -1, {31'b0, iss_ready}, 32'd1);
    @(posedge clk);

    // After reset every register reads zero and nothing is pending.
    for (int i = 0; i < NREGS / 2; i++) begin
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 5'(i), 5'(2*i), 5'(2*i+1),
                       0, 0, 2'b00, 1, 0));
    end
    //            rst we     wa0 wd0         wa1 wd1         iv ia  ra0 ra1 ed0         ed1         eb     er ebv
    tbl.push_back(mk(0, 2'b01, 5,  32'h1234,   0,  0,          0, 0,  5,  7,  32'h1234,   0,          2'b00, 1, 0));
    tbl.push_back(mk(0, 2'b00, 0,  0,          0,  0,          0, 0,  5,  0,  32'h1234,   0,          2'b00, 1, 0));
    tbl.push_back(mk(0, 2'b11, 7,  32'hAAAA,   7,  32'h5555,   0, 0,  7,  5,  32'h5555,   32'h1234,   2'b00, 1, 0));
    tbl.push_back(mk(0, 2'b01, 0,  32'hFFFF,   0,  0,          0, 0,  7,  0,  32'h5555,   0,          2'b00, 1, 0));
    tbl.push_back(mk(0, 2'b00, 0,  0,          0,  0,          1, 3,  0,  7,  0,          32'h5555,   2'b00, 1, 0));
    tbl.push_back(mk(0, 2'b00, 0,  0,          0,  0,          1, 3,  3,  5,  0,          32'h1234,   2'b01, 0, 32'h8));
    tbl.push_back(mk(0, 2'b10, 0,  0,          3,  32'h33,     1, 3,  3,  3,  32'h33,     32'h33,     2'b00, 1, 32'h8));
    tbl.push_back(mk(0, 2'b00, 0,  0,          0,  0,          0, 3,  3,  9,  32'h33,     0,          2'b01, 0, 32'h8));
    tbl.push_back(mk(0, 2'b01, 3,  32'h44,     0,  0,          0, 3,  3,  0,  32'h44,     0,          2'b00, 1, 32'h8));
    tbl.push_back(mk(0, 2'b00, 0,  0,          0,  0,          1, 9,  3,  9,  32'h44,     0,          2'b00, 1, 0));
    tbl.push_back(mk(0, 2'b00, 0,  0,          0,  0,          1, 0,  0,  9,  0,          0,          2'b10, 1, 32'h200));
    tbl.push_back(mk(1, 2'b01, 6,  32'h66,     0,  0,          1, 4,  0,  0,  0,          0,          2'b00, 1, 32'h200));
    tbl.push_back(mk(0, 2'b01, 9,  32'h7,      0,  0,          0, 9,  9,  6,  32'h7,      0,          2'b00, 1, 0));
    tbl.push_back(mk(0, 2'b00, 0,  0,          0,  0,          0, 9,  9,  3,  32'h7,      0,          2'b00, 1, 0));
    tbl.push_back(mk(0, 2'b11, 10, 32'hA0A0,   11, 32'hB0B0,   0, 0,  10, 11, 32'hA0A0,   32'hB0B0,   2'b00, 1, 0));
    tbl.push_back(mk(0, 2'b00, 0,  0,          0,  0,          0, 0,  10, 11, 32'hA0A0,   32'hB0B0,   2'b00, 1, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Drain expectations still waiting on registered read outputs.
    for (int n = 0; n < 4 && exp_q.size() > 0; n++) begin
      @(posedge clk);
      #1;
      drive(idle);
      @(negedge clk);
      pop_cmp(0);
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
